frame_stream_sequencer: RTL and testbench
=========================================

Name: frame_stream_sequencer

Overview:
- Raster-order reader for the 320x240 RGB444 camera frame buffer. Drives the buffer read address and emits one Avalon-ST video packet per frame, with sop/eop and valid/ready, towards the pixel filters, convolution and scaler path.
- Frame-synchronous configuration scheduler: requested filter selection and pitch index become active only at frame boundaries. The filter and kernel path therefore never changes mid-frame.

Parameters:
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- ADDR_W, 17, frame buffer address width; must hold H_RES*V_RES-1
- CFG_W, 3, menu selection width
- PITCH_W, 11, pitch index width
- FCNT_W, 16, frame counter width

Ports:
- clk  in  1  pixel clock (VGA 25 MHz domain)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; run frames while high
- restart  in  1  synchronous pulse; abort the current frame and restart at pixel 0
- rdaddress  out  ADDR_W  frame buffer read address, combinational lookahead
- rddata  in  12  frame buffer q; registered-address RAM with 1-cycle latency
- src_data  out  12  pixel presented downstream
- src_valid  out  1  pixel valid
- src_ready  in  1  downstream ready
- src_sop  out  1  first pixel of frame (row 0, col 0)
- src_eop  out  1  last pixel of frame (row V_RES-1, col H_RES-1)
- cfg_req_menu  in  CFG_W  requested menu selection
- cfg_req_pitch  in  PITCH_W  requested pitch index
- cfg_menu  out  CFG_W  active menu selection
- cfg_pitch  out  PITCH_W  active pitch index
- cfg_commit  out  1  one-cycle pulse when the active config updates
- frame_count  out  FCNT_W  completed frames

Behaviour:
- Reset (async assert, sync release): state IDLE; row=col=0; src_valid=0, src_sop=0, src_eop=0; cfg_menu=0, cfg_pitch=0; cfg_commit=0; frame_count=0; rdaddress=0.
- States:
  - IDLE
    - src_valid=0.
    - cfg_menu/cfg_pitch track the requests every cycle; cfg_commit pulses on any change.
    - enable=1 moves to PRIME.
  - PRIME
    - One cycle; rdaddress=0 so the RAM fetches pixel 0.
    - Next state: STREAM with src_valid=1.
  - STREAM
    - Beat = src_valid & src_ready.
    - rdaddress = beat ? address of next pixel : address of current pixel.
    - rddata therefore always matches the current pixel. Full throughput is one pixel per clock.
    - src_data = rddata.
    - Stall (src_ready=0): address, data, sop and eop held stable.
- Address:
  - rdaddress = row*H_RES + col, computed with an incremental counter; no multiplier.
  - Raster order: col wraps at H_RES-1, row increments. After (V_RES-1, H_RES-1) the next pixel is (0,0).
- src_sop = (row==0 && col==0) while src_valid; src_eop = (row==V_RES-1 && col==H_RES-1) while src_valid.
- eop beat (frame boundary), all in the same edge:
  - frame_count increments, wrapping at 2^FCNT_W.
  - cfg_menu/cfg_pitch load the values of cfg_req_* sampled on that edge.
  - cfg_commit=1 for the next cycle only if either value changed.
  - If enable=1, stream continues back-to-back with sop next beat, no bubble. If enable=0, go to IDLE.
- enable deasserted mid-frame: current frame completes; stop at its eop.
- Config requests changing mid-frame: ignored until the eop beat; last value wins.
- restart:
  - Highest priority over beat.
  - STREAM/PRIME → PRIME with row=col=0; src_valid=0 the following cycle.
  - frame_count not incremented; config not committed.
  - Ignored in IDLE.
- restart and eop beat on the same edge: restart wins, so no count and no commit.
- Reset mid-frame: immediate return to reset values.

Optional Feature:
- Macro FRAME_SEQ_TESTPAT_EN.
- Defined:
  - Extra input testpat (1 bit).
  - When testpat is high and the frame starts (sop beat or PRIME), src_data for the whole frame is 8 vertical colour bars, width H_RES/8 = 40 px. Bar colours in order: 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000.
  - testpat is latched at frame start; rddata is ignored in that frame.
- Undefined: port absent; src_data = rddata always.

Test Plan:
- Reset, enable=1, src_ready=1 constantly:
  - PRIME is 1 cycle, then 76800 consecutive valid beats.
  - sop on beat 0 only; eop on beat 76799 only.
  - Next beat is sop at address 0; frame_count=1.
- Stall check with RAM model data=address[11:0]:
  - src_ready toggles at random 50%.
  - Every beat's src_data equals the low 12 bits of its raster index; no skips or duplicates.
  - sop/eop/data stay stable during stalls.
- Config scheduling:
  - Set cfg_req_menu=3 at pixel 1000 of frame 0; cfg_menu stays 0 until the eop beat.
  - cfg_menu=3 with cfg_commit high exactly one cycle after it.
  - Requesting 3 again at the next frame gives no commit pulse.
- restart at pixel 5000:
  - src_valid low 1 cycle, then sop at address 0.
  - frame_count unchanged.
  - Pending cfg_req_pitch=25 not committed until the subsequent eop.
- enable dropped at pixel 100:
  - Frame completes to eop, then IDLE with src_valid=0.
  - In IDLE, changing cfg_req_menu 0→5 gives cfg_menu=5 next cycle plus a commit pulse.
- Async reset asserted mid-stream, not aligned to clk:
  - All outputs reach reset values immediately.
  - After release with enable=1, the first beat is sop at rdaddress 0.

Source files
------------

// File: rtl/frame_stream_sequencer.sv
// frame_stream_sequencer
//
// Raster-order reader for the camera frame buffer. It walks the buffer one
// pixel at a time, row by row, and emits one Avalon-ST video packet per
// frame (sop on pixel (0,0), eop on the last pixel). It also acts as a
// frame-synchronous configuration scheduler: the requested filter menu and
// pitch index only become active at a frame boundary, so the filter and
// kernel path never changes in the middle of a frame.
//
// Ports:
//   clk            pixel clock (VGA 25 MHz domain)
//   reset_n        asynchronous active-low reset
//   enable         level; frames are streamed while high
//   restart        synchronous pulse; abort the frame and restart at pixel 0
//   rdaddress      frame buffer read address (combinational lookahead)
//   rddata         frame buffer q, registered-address RAM, 1-cycle latency
//   src_data       pixel presented downstream
//   src_valid      pixel valid
//   src_ready      downstream ready
//   src_sop        first pixel of the frame
//   src_eop        last pixel of the frame
//   cfg_req_menu   requested menu selection
//   cfg_req_pitch  requested pitch index
//   cfg_menu       active menu selection
//   cfg_pitch      active pitch index
//   cfg_commit     one-cycle pulse when the active configuration changes
//   frame_count    number of completed frames (wraps)
//   testpat        only with FRAME_SEQ_TESTPAT_EN: replace the frame with
//                  eight vertical colour bars, latched at frame start
//
// Build option: define FRAME_SEQ_TESTPAT_EN to add the test pattern input.

module frame_stream_sequencer #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int ADDR_W  = 17,
  parameter int CFG_W   = 3,
  parameter int PITCH_W = 11,
  parameter int FCNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               restart,
  output logic [ADDR_W-1:0]  rdaddress,
  input  logic [11:0]        rddata,
  output logic [11:0]        src_data,
  output logic               src_valid,
  input  logic               src_ready,
  output logic               src_sop,
  output logic               src_eop,
  input  logic [CFG_W-1:0]   cfg_req_menu,
  input  logic [PITCH_W-1:0] cfg_req_pitch,
  output logic [CFG_W-1:0]   cfg_menu,
  output logic [PITCH_W-1:0] cfg_pitch,
  output logic               cfg_commit,
  output logic [FCNT_W-1:0]  frame_count
`ifdef FRAME_SEQ_TESTPAT_EN
  ,
  input  logic               testpat
`endif
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [CFG_W-1:0]   menu_q, menu_d;
  logic [PITCH_W-1:0] pitch_q, pitch_d;
  logic               commit_q, commit_d;

  logic beat;
  logic last_col;
  logic at_eop;
  logic cfg_changed;

  assign beat        = (state_q == STREAM) && src_ready;
  assign last_col    = (col_q == COL_W'(H_RES - 1));
  assign at_eop      = last_col && (row_q == ROW_W'(V_RES - 1));
  assign cfg_changed = (cfg_req_menu != menu_q) || (cfg_req_pitch != pitch_q);

  // Next-state and datapath update. addr_q always holds the address of the
  // pixel currently being presented; it advances by one per beat so the
  // address is row*H_RES+col without a multiplier. restart is checked before
  // the beat so an abort on the eop edge neither counts nor commits.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    fcnt_d   = fcnt_q;
    menu_d   = menu_q;
    pitch_d  = pitch_q;
    commit_d = 1'b0;

    case (state_q)
      IDLE: begin
        row_d    = '0;
        col_d    = '0;
        addr_d   = '0;
        menu_d   = cfg_req_menu;
        pitch_d  = cfg_req_pitch;
        commit_d = cfg_changed;
        if (enable) begin
          state_d = PRIME;
        end
      end

      PRIME: begin
        row_d  = '0;
        col_d  = '0;
        addr_d = '0;
        if (!restart) begin
          state_d = STREAM;
        end
      end

      STREAM: begin
        if (restart) begin
          state_d = PRIME;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end else if (beat) begin
          if (at_eop) begin
            row_d    = '0;
            col_d    = '0;
            addr_d   = '0;
            fcnt_d   = fcnt_q + FCNT_W'(1);
            menu_d   = cfg_req_menu;
            pitch_d  = cfg_req_pitch;
            commit_d = cfg_changed;
            if (!enable) begin
              state_d = IDLE;
            end
          end else if (last_col) begin
            col_d  = '0;
            row_d  = row_q + ROW_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            col_d  = col_q + COL_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
        addr_d  = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      fcnt_q   <= '0;
      menu_q   <= '0;
      pitch_q  <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      fcnt_q   <= fcnt_d;
      menu_q   <= menu_d;
      pitch_q  <= pitch_d;
      commit_q <= commit_d;
    end
  end

  // The RAM registers its address, so handing it the next address lets the
  // data for the next pixel arrive exactly when that pixel is presented.
  assign rdaddress   = addr_d;
  assign src_valid   = (state_q == STREAM);
  assign src_sop     = src_valid && (row_q == '0) && (col_q == '0);
  assign src_eop     = src_valid && at_eop;
  assign cfg_menu    = menu_q;
  assign cfg_pitch   = pitch_q;
  assign cfg_commit  = commit_q;
  assign frame_count = fcnt_q;

`ifdef FRAME_SEQ_TESTPAT_EN
  localparam int BAR_W = H_RES / 8;

  logic        frame_start;
  logic        tp_active_q;
  logic [2:0]  bar_idx;
  logic [11:0] bar_colour;

  // A new frame begins either from PRIME or from the eop beat of the
  // previous frame; testpat is sampled only there so a frame is never mixed.
  assign frame_start = (state_q == PRIME) || (beat && at_eop && !restart);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tp_active_q <= 1'b0;
    end else if (frame_start) begin
      tp_active_q <= testpat;
    end
  end

  // Bar index from comparisons against constant bar edges (no divider).
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (col_q >= COL_W'(k * BAR_W)) begin
        bar_idx = 3'(k);
      end
    end
  end

  always_comb begin
    bar_colour = 12'h000;
    case (bar_idx)
      3'd0: bar_colour = 12'hFFF;
      3'd1: bar_colour = 12'hFF0;
      3'd2: bar_colour = 12'h0FF;
      3'd3: bar_colour = 12'h0F0;
      3'd4: bar_colour = 12'hF0F;
      3'd5: bar_colour = 12'hF00;
      3'd6: bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
  end

  assign src_data = tp_active_q ? bar_colour : rddata;
`else
  assign src_data = rddata;
`endif

endmodule

// File: tb/tb_frame_stream_sequencer.sv
// Testbench for frame_stream_sequencer, built with a reduced 20x6 frame so
// several whole frames fit in a short run. The frame buffer is modelled as a
// registered-address RAM whose content is the low 12 bits of the address, so
// every pixel carries its own raster index.

module tb_frame_stream_sequencer;

  localparam int H_RES   = 20;
  localparam int V_RES   = 6;
  localparam int FRAME   = H_RES * V_RES;
  localparam int ADDR_W  = 17;
  localparam int CFG_W   = 3;
  localparam int PITCH_W = 11;
  localparam int FCNT_W  = 16;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               restart;
  logic [ADDR_W-1:0]  rdaddress;
  logic [11:0]        rddata;
  logic [11:0]        src_data;
  logic               src_valid;
  logic               src_ready;
  logic               src_sop;
  logic               src_eop;
  logic [CFG_W-1:0]   cfg_req_menu;
  logic [PITCH_W-1:0] cfg_req_pitch;
  logic [CFG_W-1:0]   cfg_menu;
  logic [PITCH_W-1:0] cfg_pitch;
  logic               cfg_commit;
  logic [FCNT_W-1:0]  frame_count;

  int errors = 0;
  int checks = 0;

  // Expected stream position and configuration state.
  int exp_idx;
  int exp_frames;
  int exp_menu;
  int exp_pitch;
  bit exp_commit;

  frame_stream_sequencer #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W),
    .CFG_W(CFG_W), .PITCH_W(PITCH_W), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .restart(restart),
    .rdaddress(rdaddress),
    .rddata(rddata),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_sop(src_sop),
    .src_eop(src_eop),
    .cfg_req_menu(cfg_req_menu),
    .cfg_req_pitch(cfg_req_pitch),
    .cfg_menu(cfg_menu),
    .cfg_pitch(cfg_pitch),
    .cfg_commit(cfg_commit),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Registered-address RAM: data = address[11:0], one cycle after the address.
  always @(posedge clk) begin
    rddata <= rdaddress[11:0];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int nextIdx(input int idx);
    return (idx == FRAME - 1) ? 0 : idx + 1;
  endfunction

  // Drive the control inputs for the next clock edge.
  task automatic applyStimulus(input logic en, input logic rst, input logic rdy);
    enable    = en;
    restart   = rst;
    src_ready = rdy;
  endtask

  // Stream n beats starting at a negedge with the DUT in STREAM. Every cycle
  // (beat or stall) checks the presented pixel against the expected index,
  // so a stall that moved data, sop or eop shows up as a wrong value.
  task automatic runBeats(input int n, input bit random_stall);
    int done  = 0;
    int guard = 0;
    bit rdy;
    while (done < n && guard < 8 * n + 50) begin
      rdy = random_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(enable, 1'b0, rdy);
      #1;
      checkOutput("valid", 32'(src_valid), 32'd1);
      checkOutput("data", 32'(src_data), 32'(exp_idx % 4096));
      checkOutput("sop", 32'(src_sop), 32'(exp_idx == 0));
      checkOutput("eop", 32'(src_eop), 32'(exp_idx == FRAME - 1));
      checkOutput("rdaddress", 32'(rdaddress),
                  32'(rdy ? nextIdx(exp_idx) : exp_idx));
      checkOutput("frame_count", 32'(frame_count), 32'(exp_frames));
      checkOutput("cfg_menu", 32'(cfg_menu), 32'(exp_menu));
      checkOutput("cfg_pitch", 32'(cfg_pitch), 32'(exp_pitch));
      checkOutput("cfg_commit", 32'(cfg_commit), 32'(exp_commit));
      @(posedge clk);
      exp_commit = 1'b0;
      if (rdy) begin
        if (exp_idx == FRAME - 1) begin
          exp_frames = (exp_frames + 1) % 65536;
          exp_commit = (int'(cfg_req_menu) != exp_menu) ||
                       (int'(cfg_req_pitch) != exp_pitch);
          exp_menu   = int'(cfg_req_menu);
          exp_pitch  = int'(cfg_req_pitch);
        end
        exp_idx = nextIdx(exp_idx);
        done++;
      end
      @(negedge clk);
      guard++;
    end
    if (done < n) begin
      checkOutput("beat_budget", 32'(done), 32'(n));
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    cfg_req_menu  = '0;
    cfg_req_pitch = '0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    exp_idx    = 0;
    exp_frames = 0;
    exp_menu   = 0;
    exp_pitch  = 0;
    exp_commit = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(src_valid), 32'd0);
    checkOutput("rst_sop", 32'(src_sop), 32'd0);
    checkOutput("rst_eop", 32'(src_eop), 32'd0);
    checkOutput("rst_rdaddress", 32'(rdaddress), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    checkOutput("rst_cfg_menu", 32'(cfg_menu), 32'd0);
    checkOutput("rst_cfg_commit", 32'(cfg_commit), 32'd0);

    // Frame 0 at full throughput after a single PRIME cycle.
    $display("[TB] full-rate frame");
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("prime_valid", 32'(src_valid), 32'd0);
    checkOutput("prime_rdaddress", 32'(rdaddress), 32'd0);
    @(negedge clk);
    runBeats(FRAME, 1'b0);
    checkOutput("f1_sop", 32'(src_sop), 32'd1);
    checkOutput("f1_data", 32'(src_data), 32'd0);
    checkOutput("f1_frame_count", 32'(frame_count), 32'd1);

    // Frame 1 with random back-pressure.
    $display("[TB] random stall frame");
    runBeats(FRAME, 1'b1);
    checkOutput("stall_frame_count", 32'(frame_count), 32'd2);

    // Frame 2: menu request mid-frame applies only at the eop beat.
    $display("[TB] config scheduling");
    runBeats(30, 1'b0);
    cfg_req_menu = 3'd3;
    runBeats(FRAME - 31, 1'b0);
    checkOutput("cfg_hold_at_eop", 32'(cfg_menu), 32'd0);
    checkOutput("cfg_eop_flag", 32'(src_eop), 32'd1);
    runBeats(1, 1'b0);
    checkOutput("cfg_menu_new", 32'(cfg_menu), 32'd3);
    checkOutput("cfg_commit_pulse", 32'(cfg_commit), 32'd1);
    runBeats(1, 1'b0);
    checkOutput("cfg_commit_drop", 32'(cfg_commit), 32'd0);
    runBeats(FRAME - 1, 1'b0);
    checkOutput("cfg_no_recommit", 32'(cfg_commit), 32'd0);
    checkOutput("cfg_f4_count", 32'(frame_count), 32'd4);

    // Frame 4: restart at pixel 70 with a pitch request pending.
    $display("[TB] restart mid-frame");
    runBeats(70, 1'b0);
    cfg_req_pitch = 11'd25;
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("rs_valid", 32'(src_valid), 32'd0);
    checkOutput("rs_rdaddress", 32'(rdaddress), 32'd0);
    checkOutput("rs_frame_count", 32'(frame_count), 32'd4);
    checkOutput("rs_cfg_pitch", 32'(cfg_pitch), 32'd0);
    checkOutput("rs_cfg_commit", 32'(cfg_commit), 32'd0);
    @(negedge clk);
    exp_idx = 0;
    runBeats(FRAME - 1, 1'b0);
    checkOutput("rs_pitch_hold", 32'(cfg_pitch), 32'd0);
    runBeats(1, 1'b0);
    checkOutput("rs_pitch_new", 32'(cfg_pitch), 32'd25);
    checkOutput("rs_commit", 32'(cfg_commit), 32'd1);
    checkOutput("rs_frame_count_after", 32'(frame_count), 32'd5);

    // Frame 5: enable dropped at pixel 10, frame still completes.
    $display("[TB] enable drop");
    runBeats(10, 1'b0);
    enable = 1'b0;
    runBeats(FRAME - 10, 1'b0);
    checkOutput("idle_valid", 32'(src_valid), 32'd0);
    checkOutput("idle_sop", 32'(src_sop), 32'd0);
    checkOutput("idle_frame_count", 32'(frame_count), 32'd6);
    @(negedge clk);
    checkOutput("idle_valid_hold", 32'(src_valid), 32'd0);
    cfg_req_menu = 3'd0;
    @(negedge clk);
    checkOutput("idle_menu0", 32'(cfg_menu), 32'd0);
    checkOutput("idle_commit0", 32'(cfg_commit), 32'd1);
    @(negedge clk);
    checkOutput("idle_commit0_drop", 32'(cfg_commit), 32'd0);
    cfg_req_menu = 3'd5;
    @(negedge clk);
    checkOutput("idle_menu5", 32'(cfg_menu), 32'd5);
    checkOutput("idle_commit5", 32'(cfg_commit), 32'd1);
    @(negedge clk);
    checkOutput("idle_commit5_drop", 32'(cfg_commit), 32'd0);

    // Asynchronous reset in the middle of a streamed frame.
    $display("[TB] async reset mid-stream");
    exp_idx    = 0;
    exp_frames = 6;
    exp_menu   = 5;
    exp_pitch  = 25;
    exp_commit = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    runBeats(40, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(src_valid), 32'd0);
    checkOutput("ar_sop", 32'(src_sop), 32'd0);
    checkOutput("ar_eop", 32'(src_eop), 32'd0);
    checkOutput("ar_rdaddress", 32'(rdaddress), 32'd0);
    checkOutput("ar_frame_count", 32'(frame_count), 32'd0);
    checkOutput("ar_cfg_menu", 32'(cfg_menu), 32'd0);
    checkOutput("ar_cfg_pitch", 32'(cfg_pitch), 32'd0);
    checkOutput("ar_cfg_commit", 32'(cfg_commit), 32'd0);
    @(negedge clk);
    cfg_req_menu  = '0;
    cfg_req_pitch = '0;
    reset_n       = 1'b1;
    @(negedge clk);
    checkOutput("ar_prime_valid", 32'(src_valid), 32'd0);
    @(negedge clk);
    exp_idx    = 0;
    exp_frames = 0;
    exp_menu   = 0;
    exp_pitch  = 0;
    exp_commit = 1'b0;
    checkOutput("ar_first_sop", 32'(src_sop), 32'd1);
    runBeats(5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: got running, expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
